// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: drains the ps2_keyboard receive FIFO one byte every two cycles,
// folds set-2 E0/F0 prefixes into single key events, and tracks the held key,
// typematic repeats, a press counter and a sticky FIFO overflow flag.
module ps2_scan_ctrl #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    input  logic             clr,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic             key_repeat,
    output logic             key_down,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_flag
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    logic [0:0]      state;
    logic [7:0]      byte_r;
    logic            ext_pend;
    logic            brk_pend;
    logic            held_ext;
    logic [TO_W-1:0] to_cnt;

    logic pop;
    logic decode;
    logic is_e0;
    logic is_f0;
    logic is_e1;
    logic is_code;
    logic held_match;
    logic cnt_inc;

    // The pop strobe is only ever issued from IDLE, so it can never repeat on
    // back-to-back cycles; reset masks it so nothing is pulled while resetting.
    assign pop        = (state == ST_IDLE) && ready && !rst;
    assign nextdata_n = !pop;
    assign decode     = (state == ST_SETTLE);

    assign is_e0      = (byte_r == 8'hE0);
    assign is_f0      = (byte_r == 8'hF0);
    assign is_e1      = (byte_r == 8'hE1);
    assign is_code    = decode && !is_e0 && !is_f0 && !is_e1;
    assign held_match = key_down && (held_code == byte_r) && (held_ext == ext_pend);
    assign cnt_inc    = is_code && !brk_pend && !held_match;

    // Two-state sequencer: capture the FIFO head on pop, then spend one cycle
    // decoding it while the FIFO updates its ready/data outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            byte_r <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ready) begin
                        byte_r <= data;
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Prefix flags and their staleness timer; an overflow means the byte
    // stream can no longer be trusted, so any half-built event is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            to_cnt   <= '0;
        end else begin
            if (decode) begin
                to_cnt <= '0;
                if (is_e0) begin
                    ext_pend <= 1'b1;
                end else if (is_f0) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end else if (ext_pend || brk_pend) begin
                if (to_cnt == TO_LAST) begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    to_cnt   <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
            if (overflow) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    // Key event outputs and held-key tracking, updated when a code byte decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
            key_down    <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (is_code) begin
                key_valid   <= 1'b1;
                key_code    <= byte_r;
                key_ext     <= ext_pend;
                key_release <= brk_pend;
                key_repeat  <= !brk_pend && held_match;
                if (!brk_pend) begin
                    if (!held_match) begin
                        key_down  <= 1'b1;
                        held_code <= byte_r;
                        held_ext  <= ext_pend;
                    end
                end else if (held_match) begin
                    key_down <= 1'b0;
                end
            end
        end
    end

    // Press counter and sticky overflow flag; clr takes priority over both.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_cnt <= '0;
            ovf_flag  <= 1'b0;
        end else if (clr) begin
            press_cnt <= '0;
            ovf_flag  <= 1'b0;
        end else begin
            if (cnt_inc) begin
                press_cnt <= press_cnt + 1'b1;
            end
            if (overflow) begin
                ovf_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Testbench for ps2_scan_ctrl: a byte FIFO feeds the design, and an
// event-level model of the scan-code rules predicts every key event.
module tb_ps2_scan_ctrl;

    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ready = 1'b0;
    logic [7:0]       data = 8'h00;
    logic             overflow = 1'b0;
    logic             clr = 1'b0;
    logic             nextdata_n;
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_release;
    logic             key_repeat;
    logic             key_down;
    logic [7:0]       held_code;
    logic [CNT_W-1:0] press_cnt;
    logic             ovf_flag;

    ps2_scan_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .data       (data),
        .overflow   (overflow),
        .clr        (clr),
        .nextdata_n (nextdata_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_release(key_release),
        .key_repeat (key_repeat),
        .key_down   (key_down),
        .held_code  (held_code),
        .press_cnt  (press_cnt),
        .ovf_flag   (ovf_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic       rep;
        logic       down;
        logic [7:0] held;
        int         cnt;
    } expEvent_t;

    expEvent_t  expQ[$];
    logic [7:0] fifoMem [0:1023];
    int         wrPtr = 0;
    int         rdPtr = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         popReq = 0;
    bit         prevPop = 0;
    bit         monitorOn = 1;

    bit         extP = 0;
    bit         brkP = 0;
    bit         heldV = 0;
    bit         heldExt = 0;
    bit         ovfM = 0;
    logic [7:0] heldCode = 8'h00;
    int         prefCyc = 0;
    int         pressM = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifoMem[wrPtr % 1024] = b;
        wrPtr++;
    endtask

    // Reference model: consumes one popped byte and predicts the resulting event.
    task automatic modelByte(input logic [7:0] b, input int c);
        expEvent_t ev;
        bit        match;
        if ((extP || brkP) && (c - prefCyc) > TIMEOUT_CYC) begin
            extP = 0;
            brkP = 0;
        end
        case (b)
            8'hE0: begin extP = 1; prefCyc = c; end
            8'hF0: begin brkP = 1; prefCyc = c; end
            8'hE1: begin extP = 0; brkP = 0; end
            default: begin
                ev.due  = c + 2;
                ev.code = b;
                ev.ext  = extP;
                ev.rel  = brkP;
                match   = heldV && (heldCode == b) && (heldExt == extP);
                if (!brkP) begin
                    ev.rep = match;
                    if (!match) begin
                        pressM   = (pressM + 1) % (1 << CNT_W);
                        heldV    = 1;
                        heldCode = b;
                        heldExt  = extP;
                    end
                end else begin
                    ev.rep = 0;
                    if (match) heldV = 0;
                end
                ev.down = heldV;
                ev.held = heldCode;
                ev.cnt  = pressM;
                expQ.push_back(ev);
                extP = 0;
                brkP = 0;
            end
        endcase
    endtask

    // One clock: FIFO update just after the rising edge, observation on the falling edge.
    task automatic tick();
        expEvent_t ev;
        @(posedge clk);
        #1;
        if (popReq && rdPtr != wrPtr) rdPtr++;
        popReq = 0;
        ready  = (rdPtr != wrPtr);
        data   = ready ? fifoMem[rdPtr % 1024] : 8'h00;
        @(negedge clk);
        cyc++;
        if (overflow) begin
            extP = 0;
            brkP = 0;
            ovfM = 1;
        end
        if (clr) begin
            ovfM   = 0;
            pressM = 0;
        end
        if (monitorOn) begin
            if (key_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious", key_valid, 0);
                end else begin
                    ev = expQ.pop_front();
                    checkOutput("evCycle", cyc, ev.due);
                    checkOutput("evCode", key_code, ev.code);
                    checkOutput("evExt", key_ext, ev.ext);
                    checkOutput("evRel", key_release, ev.rel);
                    checkOutput("evRep", key_repeat, ev.rep);
                    checkOutput("evDown", key_down, ev.down);
                    checkOutput("evHeld", held_code, ev.held);
                    checkOutput("evCnt", press_cnt, ev.cnt);
                    checkOutput("evOvf", ovf_flag, ovfM);
                end
            end else if (expQ.size() > 0 && expQ[0].due < cyc) begin
                checkOutput("evMissing", key_valid, 1);
                void'(expQ.pop_front());
            end
            if (!nextdata_n) begin
                checkOutput("popReady", ready, 1);
                checkOutput("popSpacing", prevPop, 0);
                modelByte(data, cyc);
            end
        end
        if (!nextdata_n) popReq = 1;
        prevPop = !nextdata_n;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200 && rdPtr != wrPtr; i++) tick();
        checkOutput("drain", wrPtr - rdPtr, 0);
        repeat (3) tick();
    endtask

    task automatic pulseOverflow();
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
    endtask

    task automatic pulseClr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Main sequence: reset, directed scenarios, randomized traffic, reset mid-pop.
    initial begin
        int c1;
        int strobes;
        logic [7:0] pool [0:3];
        pool[0] = 8'h15; pool[1] = 8'h1C; pool[2] = 8'h23; pool[3] = 8'h75;

        repeat (3) tick();
        checkOutput("rstNextdata", nextdata_n, 1);
        checkOutput("rstValid", key_valid, 0);
        checkOutput("rstCode", key_code, 0);
        checkOutput("rstDown", key_down, 0);
        checkOutput("rstCnt", press_cnt, 0);
        checkOutput("rstOvf", ovf_flag, 0);
        rst = 1'b0;
        tick();

        applyStimulus(8'h15);
        waitIdle();
        checkOutput("singleCnt", press_cnt, pressM);
        checkOutput("singleDown", key_down, 1);

        applyStimulus(8'hF0); applyStimulus(8'h15);
        waitIdle();
        applyStimulus(8'h15); applyStimulus(8'h15); applyStimulus(8'h15);
        applyStimulus(8'hF0); applyStimulus(8'h15);
        waitIdle();
        checkOutput("typematicDown", key_down, 0);
        checkOutput("typematicCnt", press_cnt, pressM);

        applyStimulus(8'hE0); applyStimulus(8'h75);
        waitIdle();
        checkOutput("extDown", key_down, 1);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        waitIdle();
        checkOutput("extUp", key_down, 0);

        applyStimulus(8'hF0);
        waitIdle();
        repeat (20) tick();
        applyStimulus(8'h23);
        waitIdle();

        applyStimulus(8'hF0);
        waitIdle();
        pulseOverflow();
        applyStimulus(8'h1C);
        waitIdle();
        checkOutput("ovfSet", ovf_flag, 1);
        pulseClr();
        tick();
        checkOutput("clrOvf", ovf_flag, 0);
        checkOutput("clrCnt", press_cnt, 0);

        for (int it = 0; it < 150; it++) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 4)       applyStimulus(pool[r]);
                else if (r == 4) applyStimulus(8'hE0);
                else if (r < 7)  applyStimulus(8'hF0);
                else if (r == 7) applyStimulus(8'hE1);
                else             applyStimulus(8'($urandom_range(0, 255)));
            end
            waitIdle();
            if ($urandom_range(0, 19) == 0) pulseOverflow();
            if ($urandom_range(0, 19) == 0) pulseClr();
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(30, 40)) tick();
            else repeat ($urandom_range(0, 3)) tick();
        end
        waitIdle();
        checkOutput("evLeft", expQ.size(), 0);
        checkOutput("finalOvf", ovf_flag, ovfM);
        checkOutput("finalCnt", press_cnt, pressM);

        monitorOn = 0;
        applyStimulus(8'h15); applyStimulus(8'h1C); applyStimulus(8'h23);
        for (int i = 0; i < 10 && nextdata_n; i++) tick();
        checkOutput("burstPop1", !nextdata_n, 1);
        c1 = cyc;
        tick();
        checkOutput("burstGap", nextdata_n, 1);
        tick();
        checkOutput("burstPop2", !nextdata_n, 1);
        checkOutput("burstSpacing", cyc - c1, 2);
        @(posedge clk);
        #1;
        rdPtr  = wrPtr;
        popReq = 0;
        ready  = 1'b0;
        data   = 8'h00;
        rst    = 1'b1;
        tick();
        checkOutput("midRstValid", key_valid, 0);
        checkOutput("midRstCode", key_code, 0);
        checkOutput("midRstFlags", {key_ext, key_release, key_repeat, key_down}, 0);
        checkOutput("midRstHeld", held_code, 0);
        checkOutput("midRstCnt", press_cnt, 0);
        checkOutput("midRstNext", nextdata_n, 1);
        rst = 1'b0;
        strobes = 0;
        repeat (5) begin
            tick();
            if (key_valid) strobes++;
        end
        checkOutput("midRstNoEvent", strobes, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
